// File: rtl/ram_ahb_wait_pkg.sv
// Shared types for the wait-state AHB RAM: configuration record, FSM states, counter sizing.
// The ERR states exist only when RAM_AHB_ERRRESP_EN is defined.
package ram_ahb_wait_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned PA_BITS;
    logic        FPGA;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT = '{XLEN: 32, PA_BITS: 32, FPGA: 1'b0};

`ifdef RAM_AHB_ERRRESP_EN
  typedef enum logic [2:0] {READY, WAIT, RAWSTALL, ERR1, ERR2} ramahbstate_t;
`else
  typedef enum logic [1:0] {READY, WAIT, RAWSTALL} ramahbstate_t;
`endif

  // Wait counter width; never narrower than one bit so WAIT_STATES=0 still builds.
  function automatic int unsigned cnt_width(int unsigned ws);
    return (ws < 2) ? 1 : $clog2(ws + 1);
  endfunction

endpackage

// File: rtl/ram_ahb_wait_ram1p1rwbe.sv
// Single-port synchronous RAM with per-byte write enables; dout holds when not reading.
module ram1p1rwbe #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     ce,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     we,
  input  logic [WIDTH/8-1:0]       bwe,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) begin
        for (int i = 0; i < WIDTH / 8; i++) begin
          if (bwe[i]) mem[addr][i*8 +: 8] <= din[i*8 +: 8];
        end
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ram_ahb_wait.sv
// AHB-Lite RAM slave with WAIT_STATES extra data-phase cycles and read-after-write stalling.
// Define RAM_AHB_ERRRESP_EN to add the two-cycle ERROR response for out-of-window addresses.
module ram_ahb_wait
  import ram_ahb_wait_pkg::*;
#(
  parameter cvw_t        P           = CVW_DEFAULT,
  parameter logic [63:0] BASE        = 64'h0,
  parameter logic [63:0] RANGE       = 64'hFFFF,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HSEL,
  input  logic [P.PA_BITS-1:0]   HADDR,
  input  logic                   HWRITE,
  input  logic                   HREADY,
  input  logic [1:0]             HTRANS,
  input  logic [P.XLEN-1:0]      HWDATA,
  input  logic [P.XLEN/8-1:0]    HWSTRB,
  output logic [P.XLEN-1:0]      HRDATA,
  output logic                   HRESP,
  output logic                   HREADYOUT
);

  localparam int unsigned BYTES = P.XLEN / 8;
  localparam int unsigned DEPTH = 32'((RANGE + 64'd1) / 64'(BYTES));
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LSB   = $clog2(BYTES);
  localparam int unsigned CW    = cnt_width(WAIT_STATES);

  ramahbstate_t         state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [P.PA_BITS-1:0] addr_q;
  logic                 write_q, dphase_q, err_q;
  logic                 hreadyout_q, ready_d;

  logic          accept, can_accept, take, in_range, raw;
  logic          ram_we, ram_re, ram_ce, use_q;
  logic [63:0]   off_live, off_q;
  logic [AW-1:0] ram_addr;
  logic          unused_bits;

  assign off_live = 64'(HADDR) - BASE;
  assign off_q    = 64'(addr_q) - BASE;

  assign accept = HREADY & HSEL & HTRANS[1];
`ifdef RAM_AHB_ERRRESP_EN
  assign can_accept = (state_q == READY) || (state_q == ERR2);
  assign in_range   = (64'(HADDR) >= BASE) && (off_live <= RANGE);
`else
  assign can_accept = (state_q == READY);
  assign in_range   = 1'b1;
  assign err_q      = 1'b0;
`endif
  assign take = accept & can_accept;

  // Only the last (ready) cycle of a clean write data phase touches memory.
  assign ram_we = (state_q == READY) & dphase_q & write_q & ~err_q;
  assign raw    = take & in_range & ~HWRITE & ram_we;
  assign ram_re = (take & in_range & ~HWRITE & ~raw) |
                  (((state_q == WAIT) || (state_q == RAWSTALL)) & ~write_q);
  assign ram_ce = ram_re | ram_we;

  assign use_q    = (state_q == WAIT) || (state_q == RAWSTALL) || (dphase_q & write_q) || !HREADY;
  assign ram_addr = use_q ? off_q[LSB +: AW] : off_live[LSB +: AW];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = READY;
      end
      RAWSTALL: begin
        if (WAIT_STATES > 0) begin
          state_d = WAIT;
          cnt_d   = CW'(WAIT_STATES);
        end else begin
          state_d = READY;
        end
      end
`ifdef RAM_AHB_ERRRESP_EN
      ERR1: state_d = ERR2;
`endif
      default: begin
        state_d = READY;
        if (take) begin
          if (!in_range) begin
`ifdef RAM_AHB_ERRRESP_EN
            state_d = ERR1;
`endif
          end else if (raw) begin
            state_d = RAWSTALL;
          end else if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CW'(WAIT_STATES);
          end
        end
      end
    endcase
  end

  always_comb begin
    ready_d = 1'b1;
    if ((state_d == WAIT) || (state_d == RAWSTALL)) ready_d = 1'b0;
`ifdef RAM_AHB_ERRRESP_EN
    if (state_d == ERR1) ready_d = 1'b0;
`endif
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= READY;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      dphase_q    <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= ready_d;
      // A data phase ends on any ready cycle; a new one starts only if an address was taken.
      if (can_accept) dphase_q <= take;
      if (take) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
      end
    end
  end

`ifdef RAM_AHB_ERRRESP_EN
  logic hresp_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_q   <= 1'b0;
      hresp_q <= 1'b0;
    end else begin
      hresp_q <= (state_d == ERR1) || (state_d == ERR2);
      if (take) err_q <= ~in_range;
    end
  end

  assign HRESP = hresp_q;
`else
  assign HRESP = 1'b0;
`endif

  assign HREADYOUT   = hreadyout_q;
  assign unused_bits = ^{HTRANS[0], off_live, off_q};

  ram1p1rwbe #(
    .DEPTH(DEPTH),
    .WIDTH(P.XLEN)
  ) u_ram (
    .clk (HCLK),
    .ce  (ram_ce),
    .addr(ram_addr),
    .we  (ram_we),
    .bwe (HWSTRB),
    .din (HWDATA),
    .dout(HRDATA)
  );

endmodule

// File: doc/ram_ahb_wait.md
# ram_ahb_wait

AHB-Lite on-chip RAM slave with a parametrised number of wait states, read-after-write collision stalling, and an optional AHB two-cycle ERROR response for addresses outside the mapped window. It sits in the uncore behind the AHB decoder, like the existing on-chip RAM. It is the general replacement for that RAM when the team needs slower-memory timing to exercise the AHB controller, or address-range checking.

## Interface
- P: cvw_t configuration; supplies XLEN, PA_BITS, FPGA.
- BASE, default 0: byte base address of the window.
- RANGE, default 65535: window size in bytes minus one. Depth is (RANGE+1)/(XLEN/8) words.
- WAIT_STATES, default 0: extra data-phase cycles per transfer, legal range 0..15.
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  PA_BITS  address.
- HWRITE  in  1  1 = write.
- HREADY  in  1  bus ready; the previous transfer completes when this is 1.
- HTRANS  in  2  transfer type; bit 1 = NONSEQ/SEQ.
- HWDATA  in  XLEN  write data, valid in the data phase.
- HWSTRB  in  XLEN/8  byte strobes, valid in the data phase.
- HRDATA  out  XLEN  read data.
- HRESP  out  1  1 = ERROR.
- HREADYOUT  out  1  slave ready.

## Operation
- An address phase is accepted when HREADY & HSEL & HTRANS[1]. On acceptance, HADDR and HWRITE are registered, plus the range flag when the error macro is compiled in.
- FSM states: READY, WAIT, RAWSTALL, ERR1, ERR2.
- READY:
  - Accepted in-range transfer with WAIT_STATES>0 goes to WAIT and loads counter = WAIT_STATES.
  - Accepted in-range transfer with WAIT_STATES=0 stays in READY.
  - Accepted read whose address phase coincides with a write's final data cycle goes to RAWSTALL.
  - Accepted out-of-range transfer (macro on) goes to ERR1.
- WAIT: counter decrements each cycle; on reaching 1, go to READY.
- RAWSTALL: lasts one cycle. Then go to WAIT if WAIT_STATES>0, else READY.
- ERR1 always goes to ERR2. ERR2 goes to READY.
- HREADYOUT is a registered decode of the next state. It is 0 in WAIT, RAWSTALL and ERR1, and 1 otherwise. HRESP is 1 in ERR1 and ERR2 only.
- RAM address mux:
  - Registered address during WAIT, RAWSTALL, a write data phase, or when HREADY=0.
  - Live HADDR otherwise.
- RAM write enable: asserted only on the final data-phase cycle of an in-range write (HREADYOUT=1), with HWSTRB as byte enables. Errored writes never modify memory.
- Reads:
  - Issued at the address phase, or on the RAWSTALL cycle for a stalled read.
  - The read address is held through WAIT so HRDATA stays stable.
  - HRDATA is the RAM output and is valid whenever HREADYOUT=1 in a read data phase.
- IDLE/BUSY transfers and unselected cycles get a zero-wait OKAY and no RAM access.
- Word index is taken from the address bits above log2(XLEN/8), masked to the depth.

## Timing
- Reset values: state READY, counter 0, HREADYOUT 1, HRESP 0. HRDATA is not reset and is don't-care before the first read.
- Read latency: 1 + WAIT_STATES cycles from the address phase to HREADYOUT=1. Add 1 cycle when a RAWSTALL occurs.
- Write: data sampled on the cycle HREADYOUT=1. Back-to-back writes need no stall.
- Error: exactly two data-phase cycles (0/1 then 1/1 on HREADYOUT/HRESP), with no RAM access.
- A new address phase is accepted only while HREADYOUT=1. A pipelined request issued on the final ready cycle starts immediately.
- Asserting HRESETn low mid-transfer aborts it with no write and forces the reset values asynchronously.

## Configuration
- RAM_AHB_ERRRESP_EN defined: an address is out of range when (HADDR−BASE) > RANGE or HADDR < BASE. Such transfers receive the two-cycle ERROR.
- Not defined: no range check. Addresses alias modulo depth, HRESP is tied to 0, and the ERR states are removed.

## Structure
- The FSM state enum ramahbstate_t {READY, WAIT, RAWSTALL, ERR1, ERR2} goes in the cvw package. The counter width constant is $clog2(WAIT_STATES+1), with a minimum of 1.
- One sub-module: the existing single-port byte-enable memory ram1p1rwbe, with PRELOAD_ENABLED=P.FPGA.
- Registers use the standard flop primitives with async reset.

## Test plan
- WAIT_STATES=0, write 0xDEADBEEF to BASE+0x10, then read it back → read returns 0xDEADBEEF with no HREADYOUT low cycles.
- WAIT_STATES=3, read BASE+0x20 → HREADYOUT low for exactly 3 cycles, then data; HRDATA is stable across the wait.
- Write BASE+0x8 immediately followed by a read of BASE+0x0 → one RAWSTALL cycle, and the correct old data is returned.
- Write 0x11223344 with HWSTRB=0x3 over 0xFFFFFFFF → read returns 0xFFFF3344.
- Macro on, access BASE+RANGE+1 → HREADYOUT/HRESP sequence 0/1 then 1/1; memory is unchanged; the next in-range transfer is OKAY.
- Assert HRESETn in the middle of a WAIT_STATES=3 write → no write lands, and HREADYOUT=1 immediately.
